// File: rtl/ssp_pkg.sv
// Shared SSP definitions: link FSM states, byte/word widths and the magic command word.
package ssp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ssp_state_e;

  localparam int                SSP_BYTE_W  = 8;
  localparam int                SSP_CMD_W   = 32;
  localparam logic [31:0]       SSP_MAGIC   = 32'hDEADBEEF;
  localparam int                SSP_BIT_MSB = 7;

  // Ones over the low nbytes bytes of a command word.
  function automatic logic [SSP_CMD_W-1:0] word_mask(input int nbytes);
    logic [SSP_CMD_W-1:0] m;
    m = '0;
    for (int i = 0; i < SSP_CMD_W / SSP_BYTE_W; i++) begin
      if (i < nbytes) m[i*SSP_BYTE_W +: SSP_BYTE_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ssp_rx_if.sv
// Output side of the SSP receiver: received-byte handshake plus the assembled command word.
interface ssp_rx_if;
  import ssp_pkg::*;

  // A byte transfers on every clock edge where rx_valid && rx_ready; rx_data is held
  // stable while rx_valid is high, and rx_valid only drops after such a transfer.
  // cmd_valid and magic_hit are unqualified single-cycle pulses.
  logic [SSP_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [SSP_CMD_W-1:0]  cmd_word;
  logic                  cmd_valid;
  logic                  magic_hit;

  modport master (
    output rx_data, rx_valid, cmd_word, cmd_valid, magic_hit,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, cmd_word, cmd_valid, magic_hit,
    output rx_ready
  );

endinterface

// File: rtl/ssp_clkgen.sv
// SSP master timing: divided ssp_clk, per-byte ssp_frame and a mid-bit sample strobe.
module ssp_clkgen
  import ssp_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       sample_stb,
  output logic       byte_stb,
  output ssp_state_e state
);

  logic [7:0] hcnt;
  logic [2:0] bidx;
  logic       half_done;

  assign half_done  = (hcnt == 8'(CLK_DIV - 1));
  // Sampling happens on the edge that takes ssp_clk from 1 to 0; an abort wins over it.
  assign sample_stb = (state == SHIFT) && en && half_done && ssp_clk;
  assign byte_stb   = sample_stb && (bidx == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      bidx      <= 3'(SSP_BIT_MSB);
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state     <= SHIFT;
            ssp_frame <= 1'b1;
          end
        end
        SHIFT: begin
          if (!en) begin
            state     <= IDLE;
            hcnt      <= '0;
            bidx      <= 3'(SSP_BIT_MSB);
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
          end else if (half_done) begin
            hcnt    <= '0;
            ssp_clk <= ~ssp_clk;
            if (ssp_clk) begin
              // bidx wraps 0 -> 7, so the next byte follows with no gap.
              bidx      <= bidx - 3'd1;
              ssp_frame <= (bidx == 3'd0);
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssp_rx.sv
// ARM-to-FPGA SSP receiver: MSB-first deserializer, one-deep byte buffer, command word assembly.
// Build option: define SSP_RX_MAGIC_EN to pulse magic_hit on a 32'hDEADBEEF command word.
module ssp_rx
  import ssp_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int WORD_BYTES = 4
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ssp_dout,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  ssp_rx_if.master   rx,
  output ssp_state_e state
);

  localparam logic [SSP_CMD_W-1:0] WORD_MASK = word_mask(WORD_BYTES);

  logic                  sample_stb;
  logic                  byte_stb;
  logic [6:0]            shift;
  logic [SSP_BYTE_W-1:0] new_byte;
  logic                  accept;
  logic                  drop;
  logic [SSP_CMD_W-1:0]  stage;
  logic [SSP_CMD_W-1:0]  staged_next;
  logic [1:0]            wcnt;
  logic                  word_done;

  ssp_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk        (ck_1356meg),
    .rst        (rst),
    .en         (rx_en),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .sample_stb (sample_stb),
    .byte_stb   (byte_stb),
    .state      (state)
  );

  assign new_byte    = {shift, ssp_dout};
  assign accept      = byte_stb && (!rx.rx_valid || rx.rx_ready);
  assign drop        = byte_stb && rx.rx_valid && !rx.rx_ready;
  assign staged_next = {stage[SSP_CMD_W-SSP_BYTE_W-1:0], new_byte};
  assign word_done   = accept && (wcnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      shift        <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx_overflow  <= 1'b0;
      stage        <= '0;
      wcnt         <= '0;
      rx.cmd_word  <= '0;
      rx.cmd_valid <= 1'b0;
    end else begin
      if (sample_stb) shift <= new_byte[6:0];

      if (accept) begin
        rx.rx_data  <= new_byte;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end

      if (drop)         rx_overflow <= 1'b1;
      else if (ovf_clr) rx_overflow <= 1'b0;

      rx.cmd_valid <= 1'b0;
      // Abort or a dropped byte restarts word assembly at the next byte.
      if (!rx_en || drop) begin
        wcnt <= '0;
      end else if (accept) begin
        stage <= staged_next;
        if (word_done) begin
          wcnt         <= '0;
          rx.cmd_word  <= staged_next & WORD_MASK;
          rx.cmd_valid <= 1'b1;
        end else begin
          wcnt <= wcnt + 2'd1;
        end
      end
    end
  end

`ifdef SSP_RX_MAGIC_EN
  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) rx.magic_hit <= 1'b0;
    else     rx.magic_hit <= word_done && (WORD_BYTES == 4) && (staged_next == SSP_MAGIC);
  end
`else
  assign rx.magic_hit = 1'b0;
`endif

endmodule
